dmem_boot_arbiter: RTL and testbench

Owns the single data-memory port and shares it between the RISC-V core and an external host (debug/boot loader). After reset it holds the core in reset and gives the host exclusive access so a program image can be written. On `boot_done` it releases the core, then time-shares the memory with bounded host latency by stalling the core for one cycle per host access. It sits between `riscv_cpu`, the host interface and `data_mem`.

---
 rtl/dmem_boot_arbiter.sv | 119 +++++++++++
 tb/tb_dmem_boot_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_boot_arbiter.sv
// Data-memory port arbiter between the RISC-V core and a boot/debug host.
// The host loads the image while the core is held in reset, then gets bounded-latency slots in RUN.
module dmem_boot_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_mem_en,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hold,
    output logic              cpu_rst_n,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    input  logic              boot_done,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  load_count
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic [CNT_W-1:0]  count_next;
    logic              host_read;

    // Grants are masked while reset is low so an in-flight access is aborted.
    always_comb begin
        state_next = state;
        host_gnt   = 1'b0;
        case (state)
            LOAD: begin
                host_gnt = host_req;
                if (boot_done) state_next = RELEASE;
            end
            RELEASE: state_next = RUN;
            RUN: begin
                host_gnt = host_req && (!cpu_mem_en || (wait_cnt == WAIT_LIMIT));
                if (reload) state_next = LOAD;
            end
            default: state_next = LOAD;
        endcase
        if (!reset) host_gnt = 1'b0;
    end

    assign cpu_hold  = (state == RUN) && host_gnt && cpu_mem_en;
    assign cpu_rdata = mem_rdata;
    assign host_read = host_gnt && !host_we;
    assign state_o   = state;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
        if (host_gnt) begin
            mem_we = host_we;
        end else if (state == RUN) begin
            mem_we    = cpu_we && cpu_mem_en && !cpu_hold;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    // Refusal counter only runs while a RUN request is waiting; leaving RUN clears it.
    always_comb begin
        wait_next = '0;
        if ((state == RUN) && (state_next == RUN) && host_req && !host_gnt) begin
            wait_next = (wait_cnt == WAIT_LIMIT) ? wait_cnt : wait_cnt + 1'b1;
        end
    end

    always_comb begin
        count_next = load_count;
        if ((state == RUN) && (state_next == LOAD)) begin
            count_next = '0;
        end else if ((state == LOAD) && host_gnt && host_we && (load_count != '1)) begin
            count_next = load_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= LOAD;
            wait_cnt    <= '0;
            load_count  <= '0;
            cpu_rst_n   <= 1'b0;
            host_rdata  <= '0;
            host_rvalid <= 1'b0;
        end else begin
            state       <= state_next;
            wait_cnt    <= wait_next;
            load_count  <= count_next;
            cpu_rst_n   <= (state_next == RUN);
            host_rvalid <= host_read;
            if (host_read) host_rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_dmem_boot_arbiter.sv
// Self-checking bench for dmem_boot_arbiter: directed scenarios plus randomized RUN traffic
// against a cycle-level behavioural model with its own shadow memory.
module tb_dmem_boot_arbiter;
    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 2;
    localparam int LOAD_MAX = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_mem_en, cpu_we, cpu_hold, cpu_rst_n;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        host_req, host_we, host_gnt, host_rvalid;
    logic [31:0] host_addr, host_wdata, host_rdata;
    logic        boot_done, reload;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  state_o;
    logic [CNT_W-1:0] load_count;

    int vectors = 0;
    int miscompares = 0;

    dmem_boot_arbiter #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .cpu_mem_en(cpu_mem_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold), .cpu_rst_n(cpu_rst_n),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .boot_done(boot_done), .reload(reload),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .state_o(state_o), .load_count(load_count)
    );

    // clock / environment memory (64 words, combinational read)
    always #5 clk = ~clk;

    logic [31:0] dmem [0:63] = '{default: 32'h0};
    assign mem_rdata = dmem[mem_addr[7:2]];
    always @(posedge clk) if (mem_we) dmem[mem_addr[7:2]] <= mem_wdata;

    // behavioural model: phase 0=LOAD 1=RELEASE 2=RUN
    int          m_phase, m_wait, m_load;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic [31:0] ref_mem [0:63] = '{default: 32'h0};
    logic        e_gnt, e_hold, e_we;
    logic [31:0] e_addr, e_wdata;

    task automatic model_reset();
        m_phase = 0; m_wait = 0; m_load = 0; m_rvalid = 1'b0; m_rdata = 32'h0;
    endtask

    task automatic model_comb();
        e_gnt = 1'b0;
        if (reset && host_req) begin
            if (m_phase == 0) e_gnt = 1'b1;
            else if (m_phase == 2 && (!cpu_mem_en || m_wait >= MAX_WAIT)) e_gnt = 1'b1;
        end
        e_hold = e_gnt && cpu_mem_en && (m_phase == 2);
        if (e_gnt) begin
            e_we = host_we; e_addr = host_addr; e_wdata = host_wdata;
        end else if (m_phase == 2) begin
            e_we = cpu_we && cpu_mem_en; e_addr = cpu_addr; e_wdata = cpu_wdata;
        end else begin
            e_we = 1'b0; e_addr = host_addr; e_wdata = host_wdata;
        end
    endtask

    task automatic model_update();
        m_rvalid = e_gnt && !host_we;
        if (m_rvalid) m_rdata = ref_mem[host_addr[7:2]];
        if (e_we) ref_mem[e_addr[7:2]] = e_wdata;
        if (m_phase == 0 && e_gnt && host_we && m_load < LOAD_MAX) m_load++;
        if (m_phase == 2 && host_req && !e_gnt) m_wait = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
        else m_wait = 0;
        case (m_phase)
            0: if (boot_done) m_phase = 1;
            1: m_phase = 2;
            default: if (reload) begin m_phase = 0; m_load = 0; m_wait = 0; end
        endcase
    endtask

    // driver tasks
    task automatic tick();
        model_comb();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive_idle();
        cpu_mem_en = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
        boot_done = 0; reload = 0;
    endtask

    task automatic drive_host(input logic we, input logic [31:0] addr, input logic [31:0] data);
        host_req = 1; host_we = we; host_addr = addr; host_wdata = data;
    endtask

    task automatic test_reset();
        reset = 0; drive_idle(); model_reset();
        #2;
        vectors++; if (state_o !== 2'd0) begin miscompares++; $display("FAIL rst_state: got %0d expected 0", state_o); end
        vectors++; if (cpu_rst_n !== 1'b0) begin miscompares++; $display("FAIL rst_cpu_rst_n: got %b expected 0", cpu_rst_n); end
        vectors++; if (host_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata: got %0h expected 0", host_rdata); end
        vectors++; if (host_rvalid !== 1'b0) begin miscompares++; $display("FAIL rst_rvalid: got %b expected 0", host_rvalid); end
        vectors++; if (load_count !== '0) begin miscompares++; $display("FAIL rst_load_count: got %0d expected 0", load_count); end
        vectors++; if ({host_gnt, mem_we, cpu_hold} !== 3'b000) begin miscompares++; $display("FAIL rst_comb: got %b expected 000", {host_gnt, mem_we, cpu_hold}); end
        drive_host(1'b1, 32'h0, 32'h99);
        #1;
        vectors++; if ({host_gnt, mem_we} !== 2'b00) begin miscompares++; $display("FAIL rst_req_masked: got %b expected 00", {host_gnt, mem_we}); end
        @(negedge clk);
        reset = 1; drive_idle();
        tick();
    endtask

    task automatic test_boot_load();
        for (int i = 0; i < 3; i++) begin
            drive_host(1'b1, 32'(i * 4), 32'(17 * (i + 1)));
            #1;
            vectors++; if ({host_gnt, mem_we} !== 2'b11) begin miscompares++; $display("FAIL boot_gnt: got %b expected 11", {host_gnt, mem_we}); end
            vectors++; if (mem_addr !== 32'(i * 4)) begin miscompares++; $display("FAIL boot_addr: got %0h expected %0h", mem_addr, i * 4); end
            tick();
            vectors++; if (load_count !== CNT_W'(i + 1)) begin miscompares++; $display("FAIL boot_count: got %0d expected %0d", load_count, i + 1); end
        end
        host_req = 0;
        vectors++; if (cpu_rst_n !== 1'b0) begin miscompares++; $display("FAIL boot_hold_core: got %b expected 0", cpu_rst_n); end
        vectors++; if ({dmem[0], dmem[1], dmem[2]} !== {32'h11, 32'h22, 32'h33}) begin
            miscompares++; $display("FAIL boot_mem: got %0h %0h %0h expected 11 22 33", dmem[0], dmem[1], dmem[2]); end
        boot_done = 1;
        tick();
        boot_done = 0;
        vectors++; if ({state_o, cpu_rst_n} !== {2'd1, 1'b0}) begin miscompares++; $display("FAIL boot_release: got %0d/%b expected 1/0", state_o, cpu_rst_n); end
        #1;
        vectors++; if (host_gnt !== 1'b0) begin miscompares++; $display("FAIL boot_release_gnt: got %b expected 0", host_gnt); end
        tick();
        vectors++; if ({state_o, cpu_rst_n} !== {2'd2, 1'b1}) begin miscompares++; $display("FAIL boot_run: got %0d/%b expected 2/1", state_o, cpu_rst_n); end
    endtask

    task automatic test_idle_slot();
        cpu_mem_en = 0;
        drive_host(1'b0, 32'h4, 32'h0);
        #1;
        vectors++; if ({host_gnt, cpu_hold, mem_we} !== 3'b100) begin miscompares++; $display("FAIL idle_gnt: got %b expected 100", {host_gnt, cpu_hold, mem_we}); end
        tick();
        host_req = 0;
        vectors++; if (host_rvalid !== 1'b1) begin miscompares++; $display("FAIL idle_rvalid: got %b expected 1", host_rvalid); end
        vectors++; if (host_rdata !== 32'h22) begin miscompares++; $display("FAIL idle_rdata: got %0h expected 22", host_rdata); end
        tick();
        vectors++; if (host_rvalid !== 1'b0) begin miscompares++; $display("FAIL idle_rvalid_pulse: got %b expected 0", host_rvalid); end
    endtask

    task automatic test_contention();
        cpu_mem_en = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'hDEAD;
        drive_host(1'b1, 32'h10, 32'hAA);
        for (int c = 1; c <= MAX_WAIT + 1; c++) begin
            logic g;
            g = (c == MAX_WAIT + 1);
            #1;
            vectors++; if ({host_gnt, cpu_hold} !== {g, g}) begin miscompares++; $display("FAIL cont_gnt_c%0d: got %b expected %b", c, {host_gnt, cpu_hold}, {g, g}); end
            vectors++; if ({mem_we, mem_addr} !== {1'b1, g ? 32'h10 : 32'h20}) begin
                miscompares++; $display("FAIL cont_mux_c%0d: got %b/%0h expected 1/%0h", c, mem_we, mem_addr, g ? 32'h10 : 32'h20); end
            tick();
        end
        drive_idle();
        vectors++; if ({dmem[4], dmem[8]} !== {32'hAA, 32'hDEAD}) begin miscompares++; $display("FAIL cont_mem: got %0h %0h expected aa dead", dmem[4], dmem[8]); end
    endtask

    task automatic test_simultaneous();
        drive_host(1'b0, 32'h10, 32'h0);
        reload = 1;
        #1;
        vectors++; if (host_gnt !== 1'b1) begin miscompares++; $display("FAIL sim_reload_gnt: got %b expected 1", host_gnt); end
        tick();
        drive_idle();
        vectors++; if ({host_rvalid, host_rdata} !== {1'b1, 32'hAA}) begin miscompares++; $display("FAIL sim_reload_read: got %b/%0h expected 1/aa", host_rvalid, host_rdata); end
        vectors++; if ({state_o, load_count, cpu_rst_n} !== {2'd0, CNT_W'(0), 1'b0}) begin
            miscompares++; $display("FAIL sim_reload_state: got %0d/%0d/%b expected 0/0/0", state_o, load_count, cpu_rst_n); end
        drive_host(1'b1, 32'h14, 32'h55);
        boot_done = 1;
        #1;
        vectors++; if ({host_gnt, mem_we} !== 2'b11) begin miscompares++; $display("FAIL sim_boot_gnt: got %b expected 11", {host_gnt, mem_we}); end
        tick();
        drive_idle();
        vectors++; if ({state_o, load_count} !== {2'd1, CNT_W'(1)}) begin miscompares++; $display("FAIL sim_boot_state: got %0d/%0d expected 1/1", state_o, load_count); end
        tick();
        vectors++; if ({state_o, dmem[5]} !== {2'd2, 32'h55}) begin miscompares++; $display("FAIL sim_boot_mem: got %0d/%0h expected 2/55", state_o, dmem[5]); end
    endtask

    task automatic test_random_run(input int cycles);
        logic pend = 1'b0;
        for (int n = 0; n < cycles; n++) begin
            if (!pend && $urandom_range(0, 2) == 0)
                drive_host(1'($urandom_range(0, 1)), {24'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom);
            pend = host_req;
            cpu_mem_en = ($urandom_range(0, 3) != 0);
            cpu_we     = 1'($urandom_range(0, 1));
            cpu_addr   = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            cpu_wdata  = $urandom;
            boot_done  = ($urandom_range(0, 7) == 0);
            reload     = ($urandom_range(0, 39) == 0);
            #1;
            model_comb();
            vectors++; if ({host_gnt, cpu_hold, mem_we} !== {e_gnt, e_hold, e_we}) begin
                miscompares++; $display("FAIL rnd_ctrl n=%0d: got %b expected %b", n, {host_gnt, cpu_hold, mem_we}, {e_gnt, e_hold, e_we}); end
            if (e_gnt || e_we) begin
                vectors++; if ({mem_addr, mem_wdata} !== {e_addr, e_wdata}) begin
                    miscompares++; $display("FAIL rnd_mux n=%0d: got %0h/%0h expected %0h/%0h", n, mem_addr, mem_wdata, e_addr, e_wdata); end
            end
            vectors++; if (cpu_rdata !== ref_mem[e_addr[7:2]]) begin miscompares++; $display("FAIL rnd_cpu_rdata n=%0d: got %0h expected %0h", n, cpu_rdata, ref_mem[e_addr[7:2]]); end
            tick();
            if (e_gnt) begin pend = 1'b0; host_req = 0; end
            vectors++; if ({state_o, cpu_rst_n, load_count} !== {2'(m_phase), m_phase == 2, CNT_W'(m_load)}) begin
                miscompares++; $display("FAIL rnd_regs n=%0d: got %0d/%b/%0d expected %0d/%b/%0d", n, state_o, cpu_rst_n, load_count, m_phase, m_phase == 2, m_load); end
            vectors++; if (host_rvalid !== m_rvalid) begin miscompares++; $display("FAIL rnd_rvalid n=%0d: got %b expected %b", n, host_rvalid, m_rvalid); end
            if (m_rvalid) begin
                vectors++; if (host_rdata !== m_rdata) begin miscompares++; $display("FAIL rnd_rdata n=%0d: got %0h expected %0h", n, host_rdata, m_rdata); end
            end
        end
        drive_idle();
    endtask

    task automatic test_reset_mid();
        for (int n = 0; n < 10 && m_phase != 2; n++) begin
            boot_done = (m_phase == 0);
            tick();
        end
        drive_idle();
        vectors++; if (state_o !== 2'd2) begin miscompares++; $display("FAIL mid_reach_run: got %0d expected 2", state_o); end
        drive_host(1'b0, 32'h10, 32'h0);
        #1;
        vectors++; if (host_gnt !== 1'b1) begin miscompares++; $display("FAIL mid_gnt: got %b expected 1", host_gnt); end
        #1 reset = 0;
        #1;
        model_reset();
        vectors++; if ({host_gnt, mem_we, cpu_hold, cpu_rst_n, host_rvalid} !== 5'b0) begin
            miscompares++; $display("FAIL mid_outputs: got %b expected 00000", {host_gnt, mem_we, cpu_hold, cpu_rst_n, host_rvalid}); end
        vectors++; if ({state_o, load_count, host_rdata} !== {2'd0, CNT_W'(0), 32'h0}) begin
            miscompares++; $display("FAIL mid_regs: got %0d/%0d/%0h expected 0/0/0", state_o, load_count, host_rdata); end
        @(posedge clk); #1;
        vectors++; if (host_rvalid !== 1'b0) begin miscompares++; $display("FAIL mid_no_rvalid: got %b expected 0", host_rvalid); end
        @(negedge clk);
        reset = 1; drive_idle();
        tick();
        vectors++; if ({state_o, cpu_rst_n} !== {2'd0, 1'b0}) begin miscompares++; $display("FAIL mid_after: got %0d/%b expected 0/0", state_o, cpu_rst_n); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            drive_host(1'b1, 32'h40 + 32'(i * 4), $urandom);
            tick();
            vectors++; if (load_count !== CNT_W'((i + 1 > 3) ? 3 : i + 1)) begin
                miscompares++; $display("FAIL sat_count_%0d: got %0d expected %0d", i, load_count, (i + 1 > 3) ? 3 : i + 1); end
        end
        drive_idle();
    endtask

    task automatic test_memory_image();
        for (int i = 0; i < 64; i++) begin
            vectors++; if (dmem[i] !== ref_mem[i]) begin miscompares++; $display("FAIL mem_word_%0d: got %0h expected %0h", i, dmem[i], ref_mem[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_boot_load();
        test_idle_slot();
        test_contention();
        test_simultaneous();
        test_random_run(600);
        test_reset_mid();
        test_saturation();
        tick();
        test_memory_image();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
